seg_scan_driver: RTL

- Time-multiplexed N-digit hexadecimal 7-segment display driver; parametrised successor to the fixed three-digit combinational hex decoder.
- Latches a DATA_W-bit value through a load strobe and scans one digit per refresh slot, driving a shared segment bus plus one-hot digit enables.
- New values are committed only at frame boundaries, so a displayed frame never mixes old and new digits.
- Sits between the datapath and the board display pins.

---
 rtl/seg_scan_driver.sv | 109 ++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit hex 7-segment driver with frame-aligned value commit.
// Optional: define SEG_SCAN_LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero digit.
module seg_scan_driver #(
  parameter int DATA_W         = 10,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  localparam int DIGITS        = (DATA_W + 3) / 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] value,
  input  logic              load,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              frame_tick,
  output logic              pending
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int EW = DIGITS * 4;

  localparam logic [PW-1:0]     PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]     PRESC_PRE  = PW'(REFRESH_DIV - 2);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_ONE     = DIGITS'(1);
  localparam logic [6:0]        SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF     = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]     presc;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] disp;
  logic              slot_end;
  logic              wrap;
  logic              tick_next;
  logic [EW-1:0]     disp_ext;
  logic [3:0]        nib;
  logic              blank;
  logic [6:0]        seg_hi;
  logic [DIGITS-1:0] an_hi;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign slot_end = (presc == PRESC_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);
  // frame_tick is registered, so it is precomputed one cycle early to land on the wrap cycle itself.
  assign tick_next = (presc == PRESC_PRE) && (idx == IDX_LAST);
  assign disp_ext  = EW'(disp);
  assign nib       = disp_ext[{idx, 2'b00} +: 4];

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;

  always_comb begin
    msd = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (disp_ext[i*4 +: 4] != 4'h0) msd = IW'(i);
    end
    blank = (idx > msd);
  end
`else
  assign blank = 1'b0;
`endif

  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    seg_hi = blank ? 7'h00 : hex7(nib);
    an_hi  = AN_ONE << idx;
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      seg        <= SEG_OFF;
      an         <= AN_OFF;
    end else begin
      presc      <= slot_end ? '0 : presc + 1'b1;
      frame_tick <= tick_next;
      if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (load) shadow <= value;
      // A load coinciding with the wrap bypasses the shadow and lands in this new frame.
      if (wrap) begin
        if (load)         disp <= value;
        else if (pending) disp <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
      seg <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
      an  <= AN_ACTIVE_LOW ? ~an_hi : an_hi;
    end
  end

endmodule
